// File: rtl/fs_fifo_pkg.sv
// Shared helpers for the show-ahead FIFO: elaboration-time parameter checks.
package fs_fifo_pkg;

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fs_fifo.sv
// Single-clock first-word-fall-through FIFO with registered fill level.
// The head word is presented combinationally from storage; a read strobe pops it.
module fs_fifo
    import fs_fifo_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      filled_o
);

    generate
        if (!is_pow2(DEPTH)) begin : g_depth_chk
            $error("fs_fifo: DEPTH must be a power of two and >= 2");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      filled_q;
    logic             wr_acc;
    logic             rd_acc;

    // A write into a full FIFO is still taken when the same edge frees a slot.
    assign wr_acc = wr_i && (!full_o || rd_i);
    assign rd_acc = rd_i && !empty_o;

    assign filled_o = filled_q;
    assign full_o   = (filled_q == (AW+1)'(DEPTH));
    assign empty_o  = (filled_q == '0);

    assign rd_data_o = empty_o ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            filled_q <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            filled_q <= filled_q + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
        end
    end

endmodule

// File: tb/tb_fs_fifo.sv
// Directed bench for fs_fifo (WIDTH=16, DEPTH=16) with immediate-assertion checks.
module tb_fs_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk_i = 1'b0;
    logic             reset_i = 1'b0;
    logic             wr_i = 1'b0;
    logic [WIDTH-1:0] wr_data_i = '0;
    logic             rd_i = 1'b0;
    logic [WIDTH-1:0] rd_data_o;
    logic             full_o;
    logic             empty_o;
    logic [AW:0]      filled_o;

    int checks = 0;
    int errors = 0;

    fs_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .wr_i      (wr_i),
        .wr_data_i (wr_data_i),
        .rd_i      (rd_i),
        .rd_data_o (rd_data_o),
        .full_o    (full_o),
        .empty_o   (empty_o),
        .filled_o  (filled_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic status(input string tag, input int fill, input logic [15:0] head);
        check({tag, " filled"}, 32'(filled_o), 32'(fill));
        check({tag, " empty"},  32'(empty_o),  32'(fill == 0));
        check({tag, " full"},   32'(full_o),   32'(fill == DEPTH));
        check({tag, " data"},   32'(rd_data_o), 32'(head));
    endtask

    // Drive one cycle of strobes; returns #1 after the rising edge with strobes cleared.
    task automatic cyc(input logic w, input logic [15:0] d, input logic r);
        wr_i = w; wr_data_i = d; rd_i = r;
        @(posedge clk_i); #1;
        wr_i = 1'b0; rd_i = 1'b0; wr_data_i = '0;
    endtask

    initial begin
        #3;
        status("reset_init", 0, 16'h0);
        @(posedge clk_i); #1;
        reset_i = 1'b1;

        // Reset mid-traffic with five entries stored.
        for (int i = 1; i <= 5; i++) cyc(1'b1, 16'(i), 1'b0);
        status("pre_reset", 5, 16'h0001);
        #2 reset_i = 1'b0;
        #1 status("async_reset", 0, 16'h0);
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        cyc(1'b1, 16'hA5A5, 1'b0);
        status("post_reset_wr", 1, 16'hA5A5);
        cyc(1'b0, 16'h0, 1'b1);
        status("post_reset_pop", 0, 16'h0);

        // Fill to full, overflow write dropped, drain in order.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 16'(i), 1'b0);
        status("filled", 16, 16'h0000);
        cyc(1'b1, 16'hFFFF, 1'b0);
        status("overflow_drop", 16, 16'h0000);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_head", 32'(rd_data_o), 32'(i));
            cyc(1'b0, 16'h0, 1'b1);
        end
        status("drained", 0, 16'h0);

        // Wrap-around bursts: pointers cross the top index several times.
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < 3; k++) cyc(1'b1, 16'(16'h0100 + b * 3 + k), 1'b0);
            check("burst_fill", 32'(filled_o), 32'd3);
            for (int k = 0; k < 3; k++) begin
                check("burst_head", 32'(rd_data_o), 32'(16'h0100 + b * 3 + k));
                cyc(1'b0, 16'h0, 1'b1);
            end
            check("burst_empty", 32'(filled_o), 32'd0);
        end

        // Simultaneous read+write while full.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 16'(16'h0020 + i), 1'b0);
        status("full_again", 16, 16'h0020);
        cyc(1'b1, 16'h1234, 1'b1);
        status("full_rdwr", 16, 16'h0021);
        for (int i = 1; i < DEPTH; i++) begin
            check("full_rdwr_head", 32'(rd_data_o), 32'(16'h0020 + i));
            cyc(1'b0, 16'h0, 1'b1);
        end
        status("new_word_last", 1, 16'h1234);
        cyc(1'b0, 16'h0, 1'b1);
        status("after_last", 0, 16'h0);

        // Simultaneous read+write while empty: read ignored.
        cyc(1'b1, 16'hBEEF, 1'b1);
        status("empty_rdwr", 1, 16'hBEEF);
        cyc(1'b0, 16'h0, 1'b1);
        status("empty_rdwr_pop", 0, 16'h0);

        // Underflow reads are ignored.
        for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0, 1'b1);
        status("underflow", 0, 16'h0);
        cyc(1'b1, 16'h7777, 1'b0);
        status("after_underflow", 1, 16'h7777);
        cyc(1'b0, 16'h0, 1'b1);
        status("final", 0, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
